// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with shared-adder sequencing, redirect flush and halt
// Owns pc_o and arbitrates the external 32-bit PC adder between sequential fetch and taken branches.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] INSTR_BYTES  = 32'd4,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        halt_i,
    input  logic        resume_i,
    input  logic [31:0] add_sum_i,
    output logic [31:0] add_a_o,
    output logic [31:0] add_b_o,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        branch_win;

    // The branch only owns the adder when nothing of higher priority claims this edge.
    assign branch_win = (state_q == ST_RUN) && !halt_i && !jump_i && branch_taken_i;

    assign add_a_o    = pc_q;
    assign add_b_o    = branch_win ? branch_offset_i : INSTR_BYTES;

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign flush_o    = flush_q;
    assign halted_o   = halted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INIT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        flush_d  = flush_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end

            ST_RUN: begin
                if (halt_i) begin
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (jump_i) begin
                    pc_d    = jump_target_i;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                    flush_d = 1'b1;
                end else if (branch_taken_i) begin
                    pc_d    = add_sum_i;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                    flush_d = 1'b1;
                end else if (!stall_i) begin
                    pc_d = add_sum_i;
                end
            end

            ST_FLUSH: begin
                // Redirect requests seen here belong to squashed instructions.
                if (halt_i) begin
                    state_d  = ST_HALT;
                    cnt_d    = 2'd0;
                    flush_d  = 1'b0;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    if (!stall_i) begin
                        pc_d = add_sum_i;
                    end
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        flush_d = 1'b0;
                        cnt_d   = 2'd0;
                    end
                end
            end

            ST_HALT: begin
                if (resume_i) begin
                    state_d  = ST_RUN;
                    valid_d  = 1'b1;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with FLUSH_CYCLES=1 and =3 instances
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_off = 32'd0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_tgt = 32'd0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;

    logic [31:0] add_a [2];
    logic [31:0] add_b [2];
    logic [31:0] add_sum [2];
    logic [31:0] pc [2];
    logic        pc_valid [2];
    logic        flush [2];
    logic        halted [2];

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    assign add_sum[0] = add_a[0] + add_b[0];
    assign add_sum[1] = add_a[1] + add_b[1];

    pc_sequencer #(.RESET_PC(32'h0), .INSTR_BYTES(32'd4), .FLUSH_CYCLES(1)) u_f1 (
        .clk(clk), .reset(reset), .stall_i(stall), .branch_taken_i(br),
        .branch_offset_i(br_off), .jump_i(jmp), .jump_target_i(jmp_tgt),
        .halt_i(halt), .resume_i(resume), .add_sum_i(add_sum[0]),
        .add_a_o(add_a[0]), .add_b_o(add_b[0]), .pc_o(pc[0]),
        .pc_valid_o(pc_valid[0]), .flush_o(flush[0]), .halted_o(halted[0])
    );

    pc_sequencer #(.RESET_PC(32'h0), .INSTR_BYTES(32'd4), .FLUSH_CYCLES(3)) u_f3 (
        .clk(clk), .reset(reset), .stall_i(stall), .branch_taken_i(br),
        .branch_offset_i(br_off), .jump_i(jmp), .jump_target_i(jmp_tgt),
        .halt_i(halt), .resume_i(resume), .add_sum_i(add_sum[1]),
        .add_a_o(add_a[1]), .add_b_o(add_b[1]), .pc_o(pc[1]),
        .pc_valid_o(pc_valid[1]), .flush_o(flush[1]), .halted_o(halted[1])
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addb;
        logic        valid;
        logic        flush;
        logic        halted;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: fetch pointer, "has fetched since reset", halted flag, flush cycles remaining.
    logic [31:0] m_pc [2];
    bit          m_started [2];
    bit          m_halted [2];
    int          m_left [2];
    int          flush_len [2] = '{1, 3};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0;
            m_started[k] = 1'b0;
            m_halted[k] = 1'b0;
            m_left[k] = 0;
        end
    endtask

    function automatic exp_t model_view(int k);
        exp_t e;
        bool_branch: begin
            bit owns;
            owns = m_started[k] && !m_halted[k] && (m_left[k] == 0) && !halt && !jmp && br;
            e.addb = owns ? br_off : 32'd4;
        end
        e.pc     = m_pc[k];
        e.valid  = m_started[k] && !m_halted[k];
        e.flush  = (m_left[k] > 0);
        e.halted = m_halted[k];
        return e;
    endfunction

    task automatic model_step(int k);
        if (!m_started[k]) begin
            m_started[k] = 1'b1;
        end else if (m_halted[k]) begin
            if (resume) m_halted[k] = 1'b0;
        end else if (m_left[k] > 0) begin
            if (halt) begin
                m_halted[k] = 1'b1;
                m_left[k] = 0;
            end else begin
                if (!stall) m_pc[k] = m_pc[k] + 32'd4;
                m_left[k] = m_left[k] - 1;
            end
        end else if (halt) begin
            m_halted[k] = 1'b1;
        end else if (jmp) begin
            m_pc[k] = jmp_tgt;
            m_left[k] = flush_len[k];
        end else if (br) begin
            m_pc[k] = m_pc[k] + br_off;
            m_left[k] = flush_len[k];
        end else if (!stall) begin
            m_pc[k] = m_pc[k] + 32'd4;
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, record what the DUT must show now, then advance the model.
    task automatic cyc(bit s, bit b, logic [31:0] off, bit j, logic [31:0] tgt, bit h, bit r, bit rst);
        @(negedge clk);
        stall = s; br = b; br_off = off; jmp = j; jmp_tgt = tgt; halt = h; resume = r;
        reset = rst;
        if (rst) model_reset();
        q0.push_back(model_view(0));
        q1.push_back(model_view(1));
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic free(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic compare(int k, exp_t e);
        string p;
        p = (k == 0) ? "f1" : "f3";
        chk({p, ".pc_o"}, pc[k], e.pc);
        chk({p, ".add_a_o"}, add_a[k], e.pc);
        chk({p, ".add_b_o"}, add_b[k], e.addb);
        chk({p, ".pc_valid_o"}, {31'd0, pc_valid[k]}, {31'd0, e.valid});
        chk({p, ".flush_o"}, {31'd0, flush[k]}, {31'd0, e.flush});
        chk({p, ".halted_o"}, {31'd0, halted[k]}, {31'd0, e.halted});
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (q0.size() > 0) compare(0, q0.pop_front());
            if (q1.size() > 0) compare(1, q1.pop_front());
        end
    end

    initial begin : stimulus
        model_reset();
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        free(3);
        cyc(0, 1, 32'hFFFF_FFF8, 0, 32'h0, 0, 0, 0);
        free(3);
        cyc(1, 1, 32'h0000_0040, 1, 32'h0000_0100, 0, 0, 0);
        cyc(0, 1, 32'h0000_0080, 0, 32'h0, 0, 0, 0);
        free(3);
        cyc(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        free(3);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        free(2);
        cyc(0, 0, 32'h0, 1, 32'h0000_0020, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'h10, 1, 32'h0000_0300, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 1, 0);
        free(3);
        cyc(0, 0, 32'h0, 1, 32'h0000_0040, 0, 0, 0);
        free(1);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        free(2);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] off;
            logic [31:0] tgt;
            off = ($urandom_range(0, 3) == 0) ? $urandom() : ({$urandom_range(0, 63), 2'b00} - 32'd128);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 1023), 2'b00};
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, off,
                $urandom_range(0, 11) == 0, tgt, $urandom_range(0, 24) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        end
        free(2);

        @(negedge clk);
        #5;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
